// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code parser: pops bytes from the receiver, decodes make/break/E0 sequences,
// tracks held keys and counts distinct presses. TYPEMATIC_EVT_EN makes repeats emit events.
module ps2_key_tracker #(
    parameter int MAX_HELD = 4,
    parameter int CNT_W    = 8,
    parameter int HC_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ready,
    input  logic [7:0]       data,
    output logic             nextdata_n,
    output logic             evt_valid,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic             evt_repeat,
    output logic [CNT_W-1:0] press_count,
    output logic [HC_W-1:0]  held_count,
    output logic [7:0]       last_code,
    output logic             last_ext,
    output logic             table_full,
    output logic [1:0]       dbg_state
);

    localparam int IDX_W = (MAX_HELD > 1) ? $clog2(MAX_HELD) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [HC_W-1:0]  HC_ONE  = 1;

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;

    // Handshake: a byte is taken on an edge with ready=1 and nextdata_n=1; that edge
    // drives nextdata_n low for exactly one cycle, so the receiver pops once per byte.
    state_t             state_q, state_d;
    logic               nextdata_n_q, nextdata_n_d;
    logic               evt_valid_q, evt_valid_d;
    logic [7:0]         evt_code_q, evt_code_d;
    logic               evt_ext_q, evt_ext_d;
    logic               evt_break_q, evt_break_d;
    logic [CNT_W-1:0]   press_count_q, press_count_d;
    logic [HC_W-1:0]    held_count_q, held_count_d;
    logic [7:0]         last_code_q, last_code_d;
    logic               last_ext_q, last_ext_d;
    logic               table_full_q, table_full_d;
    logic [MAX_HELD-1:0] tbl_valid_q, tbl_valid_d;
    logic [MAX_HELD-1:0] tbl_ext_q, tbl_ext_d;
    logic [7:0]         tbl_code_q [MAX_HELD];
    logic [7:0]         tbl_code_d [MAX_HELD];
`ifdef TYPEMATIC_EVT_EN
    logic               evt_repeat_q, evt_repeat_d;
`endif

    logic             accept;
    logic             key_ext;
    logic             is_break;
    logic             hit;
    logic             free;
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] free_idx;

    assign accept   = ready && nextdata_n_q;
    assign key_ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    assign is_break = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);

    // Lookup uses pre-edge table contents; descending scan leaves the lowest free slot.
    always_comb begin
        hit      = 1'b0;
        free     = 1'b0;
        hit_idx  = '0;
        free_idx = '0;
        for (int i = MAX_HELD - 1; i >= 0; i--) begin
            if (!tbl_valid_q[i]) begin
                free     = 1'b1;
                free_idx = i[IDX_W-1:0];
            end
            if (tbl_valid_q[i] && (tbl_ext_q[i] == key_ext) && (tbl_code_q[i] == data)) begin
                hit     = 1'b1;
                hit_idx = i[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        nextdata_n_d  = ~accept;
        evt_valid_d   = 1'b0;
        evt_code_d    = evt_code_q;
        evt_ext_d     = evt_ext_q;
        evt_break_d   = evt_break_q;
        press_count_d = press_count_q;
        held_count_d  = held_count_q;
        last_code_d   = last_code_q;
        last_ext_d    = last_ext_q;
        table_full_d  = table_full_q;
        tbl_valid_d   = tbl_valid_q;
        tbl_ext_d     = tbl_ext_q;
        tbl_code_d    = tbl_code_q;
`ifdef TYPEMATIC_EVT_EN
        evt_repeat_d  = evt_repeat_q;
`endif
        if (accept) begin
            if (data == 8'hE0) begin
                state_d = is_break ? ST_EXT_BRK : ST_EXT;
            end else if (data == 8'hF0) begin
                state_d = key_ext ? ST_EXT_BRK : ST_BRK;
            end else begin
                state_d = ST_IDLE;
                if (is_break) begin
                    evt_valid_d = 1'b1;
                    evt_code_d  = data;
                    evt_ext_d   = key_ext;
                    evt_break_d = 1'b1;
`ifdef TYPEMATIC_EVT_EN
                    evt_repeat_d = 1'b0;
`endif
                    if (hit) begin
                        tbl_valid_d[hit_idx] = 1'b0;
                        held_count_d         = held_count_q - HC_ONE;
                    end
                end else if (hit) begin
`ifdef TYPEMATIC_EVT_EN
                    evt_valid_d  = 1'b1;
                    evt_code_d   = data;
                    evt_ext_d    = key_ext;
                    evt_break_d  = 1'b0;
                    evt_repeat_d = 1'b1;
`endif
                end else begin
                    evt_valid_d   = 1'b1;
                    evt_code_d    = data;
                    evt_ext_d     = key_ext;
                    evt_break_d   = 1'b0;
`ifdef TYPEMATIC_EVT_EN
                    evt_repeat_d  = 1'b0;
`endif
                    press_count_d = press_count_q + CNT_ONE;
                    last_code_d   = data;
                    last_ext_d    = key_ext;
                    if (free) begin
                        tbl_valid_d[free_idx] = 1'b1;
                        tbl_ext_d[free_idx]   = key_ext;
                        tbl_code_d[free_idx]  = data;
                        held_count_d          = held_count_q + HC_ONE;
                    end else begin
                        table_full_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            nextdata_n_q  <= 1'b1;
            evt_valid_q   <= 1'b0;
            evt_code_q    <= 8'h00;
            evt_ext_q     <= 1'b0;
            evt_break_q   <= 1'b0;
            press_count_q <= '0;
            held_count_q  <= '0;
            last_code_q   <= 8'h00;
            last_ext_q    <= 1'b0;
            table_full_q  <= 1'b0;
            tbl_valid_q   <= '0;
            tbl_ext_q     <= '0;
            for (int i = 0; i < MAX_HELD; i++) tbl_code_q[i] <= 8'h00;
`ifdef TYPEMATIC_EVT_EN
            evt_repeat_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            nextdata_n_q  <= nextdata_n_d;
            evt_valid_q   <= evt_valid_d;
            evt_code_q    <= evt_code_d;
            evt_ext_q     <= evt_ext_d;
            evt_break_q   <= evt_break_d;
            press_count_q <= press_count_d;
            held_count_q  <= held_count_d;
            last_code_q   <= last_code_d;
            last_ext_q    <= last_ext_d;
            table_full_q  <= table_full_d;
            tbl_valid_q   <= tbl_valid_d;
            tbl_ext_q     <= tbl_ext_d;
            tbl_code_q    <= tbl_code_d;
`ifdef TYPEMATIC_EVT_EN
            evt_repeat_q  <= evt_repeat_d;
`endif
        end
    end

    assign nextdata_n  = nextdata_n_q;
    assign evt_valid   = evt_valid_q;
    assign evt_code    = evt_code_q;
    assign evt_ext     = evt_ext_q;
    assign evt_break   = evt_break_q;
    assign press_count = press_count_q;
    assign held_count  = held_count_q;
    assign last_code   = last_code_q;
    assign last_ext    = last_ext_q;
    assign table_full  = table_full_q;
    assign dbg_state   = state_q;
`ifdef TYPEMATIC_EVT_EN
    assign evt_repeat  = evt_repeat_q;
`else
    assign evt_repeat  = 1'b0;
`endif

endmodule
